clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the divisor width in bits.
REQ-002 SHALL have parameter DIV_RST, default 3, meaning the divisor in effect after reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock. All logic SHALL be on posedge, except one negedge flop (REQ-011).
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: run request.
REQ-006 SHALL have port div_val, input, DIV_W bits: requested divisor N.
REQ-007 SHALL have port div_load, input, 1 bit: a one-cycle strobe that samples div_val.
REQ-008 SHALL have port div_busy, output, 1 bit: a loaded divisor is pending and not yet applied.
REQ-009 SHALL have port div_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-010 SHALL have ports clk_out, output, 1 bit (divided clock, 50% duty for any N ≥ 2) and tick, output, 1 bit (one-clk_in-cycle pulse marking the first high cycle of each clk_out period).

Function
REQ-011 SHALL derive clk_out as follows:
- q_pos: posedge flop = (cnt < H), where H = floor((N+1)/2).
- q_neg: negedge copy of q_pos.
- Even N: clk_out = q_pos.
- Odd N: clk_out = q_pos AND q_neg, giving N/2 clk_in periods high.
REQ-012 SHALL count cnt from 0 to N-1 and wrap to 0; the wrap edge is the edge at which cnt == N-1.
REQ-013 SHALL implement FSM IDLE/RUN:
- IDLE -> RUN on a posedge with en=1.
- RUN -> IDLE only on a wrap edge with en=0.
- en=0 mid-period completes the current period with no truncated pulse.
REQ-014 SHALL hold cnt=0, q_pos=0, q_neg=0 and tick=0 in IDLE.
REQ-015 SHALL give start-up latency: en sampled high at edge E0 -> clk_out rises at E1, and tick=1 during the cycle following E1.
REQ-016 SHALL register tick high on each RUN edge where cnt == 0.
REQ-017 SHALL handle div_load with div_val < 2 by pulsing div_err for one cycle; the divisor and pending state remain unchanged.
REQ-018 SHALL handle a legal div_load by storing div_val to div_nxt and setting div_busy=1.
REQ-019 SHALL apply div_nxt and clear div_busy together, either at the next wrap edge in RUN or at the next edge in IDLE; the new N takes effect from cnt=0.
REQ-020 SHALL handle a div_load coinciding with a wrap edge by storing the value only and applying it at the following wrap; the current divisor SHALL NOT be changed at that edge.
REQ-021 SHALL handle a div_load while div_busy=1 by overwriting div_nxt; only the last value is applied.
REQ-022 SHALL size all comparisons on DIV_W bits with no overflow at N = 2^DIV_W-1; H SHALL be computed as (N>>1) + N[0].

Reset
REQ-023 SHALL, while rst_n=0, immediately set:
- state=IDLE, cnt=0, q_pos=0, q_neg=0;
- clk_out=0, tick=0, div_busy=0, div_err=0;
- current divisor = DIV_RST, discarding any pending load.
REQ-024 SHALL let reset asserted mid-period truncate clk_out; this is the only permitted truncation.

Structure
REQ-025 SHALL place the following in package clk_div_pkg: the state enum (IDLE, RUN), constant MIN_DIV=2, and the default values for DIV_W and DIV_RST.
REQ-026 SHALL be a single module with no sub-module; the negedge flop is inline.

Verification
REQ-027 SHALL cover N=3 with en=1 held: clk_out period 3 clk_in, high 1.5 periods, tick every 3 cycles.
REQ-028 SHALL cover N=4: high 2 cycles, low 2 cycles; N=2: high 1, low 1.
REQ-029 SHALL cover running N=5 with load 2 at cnt=1: the current period completes at 5 cycles, then the period is 2, with div_busy high until that wrap.
REQ-030 SHALL cover load div_val=1 and div_val=0: div_err pulses once per load, and the period stays unchanged.
REQ-031 SHALL cover en dropped while clk_out is high (N=7): the period completes at 7 cycles, then clk_out stays 0 and tick stays 0.
REQ-032 SHALL cover rst_n pulsed low mid-RUN: clk_out=0 asynchronously; after release with en=1 the period is DIV_RST=3.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable 50%-duty clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV     = 2;
  localparam int DIV_W_DEF   = 8;
  localparam int DIV_RST_DEF = 3;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable clock divider: 50% duty clk_out for any N >= 2, period-aligned
// divisor reloads, clean start/stop on period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_nxt;
  logic             r_busy;
  logic             r_err;
  logic             r_q_pos;
  logic             r_q_neg;
  logic             r_tick;

  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_last;
  logic             w_wrap;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply;

  // H = ceil(N/2) without the N+1 overflow at N = 2^DIV_W-1.
  assign w_half     = (r_div >> 1) + {{(DIV_W-1){1'b0}}, r_div[0]};
  assign w_last     = r_div - DIV_W'(1);
  assign w_wrap     = (r_state == RUN) && (r_cnt == w_last);
  assign w_load_ok  = div_load && (div_val >= DIV_W'(MIN_DIV));
  assign w_load_bad = div_load && !w_load_ok;
  // A load landing on the apply edge wins; the new value waits for the next boundary.
  assign w_apply    = r_busy && !w_load_ok && ((r_state == IDLE) || w_wrap);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div     <= DIV_W'(DIV_RST);
      r_div_nxt <= DIV_W'(DIV_RST);
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_q_pos   <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples the pre-edge values.
      r_err <= w_load_bad;

      if (w_load_ok) begin
        r_div_nxt <= div_val;
        r_busy    <= 1'b1;
      end else if (w_apply) begin
        r_div  <= r_div_nxt;
        r_busy <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_q_pos <= 1'b0;
          r_tick  <= 1'b0;
          if (en) r_state <= RUN;
        end
        RUN: begin
          r_tick  <= (r_cnt == '0);
          r_q_pos <= (r_cnt < w_half);
          if (w_wrap) begin
            r_cnt <= '0;
            if (!en) r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // Half-cycle delayed copy; ANDed in for odd N to trim the high phase by half a period.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) r_q_neg <= 1'b0;
    else        r_q_neg <= r_q_pos;
  end

  assign clk_out  = r_div[0] ? (r_q_pos & r_q_neg) : r_q_pos;
  assign tick     = r_tick;
  assign div_busy = r_busy;
  assign div_err  = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: period-level reference model compared
// every half cycle, plus directed literal checks on periods and pulses.
module tb_clk_div_prog;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_busy;
  logic       div_err;
  logic       clk_out;
  logic       tick;

  clk_div_prog #(.DIV_W(8), .DIV_RST(3)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks which posedge starts each clk_out period and the divisor
  // in force for it; waveform is derived from the half-cycle offset into the period.
  int e_cnt    = 0;
  bit m_run    = 0;
  int m_start  = 0;
  int m_n      = 3;
  bit m_pend   = 0;
  int m_pend_n = 0;
  bit m_err    = 0;
  bit m_load_ok;
  bit m_at_end;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 0;
      m_n    = 3;
      m_pend = 0;
      m_err  = 0;
    end else begin
      e_cnt++;
      m_load_ok = div_load && (div_val >= 8'd2);
      m_at_end  = !m_run || (e_cnt - m_start == m_n - 1);
      if (m_at_end) begin
        if (m_pend && !m_load_ok) begin
          m_n    = m_pend_n;
          m_pend = 0;
        end
        if (en) begin
          m_run   = 1;
          m_start = e_cnt + 1;
        end else begin
          m_run = 0;
        end
      end
      if (m_load_ok) begin
        m_pend   = 1;
        m_pend_n = int'(div_val);
      end
      m_err = div_load && (div_val < 8'd2);
    end
  end

  function automatic logic exp_clk(input bit neg_half);
    int t;
    int lo;
    if (!m_run) return 1'b0;
    t  = 2 * (e_cnt - m_start) + int'(neg_half);
    lo = m_n % 2;
    return (t >= lo) && (t < m_n + lo);
  endfunction

  function automatic logic exp_tick();
    return m_run && (e_cnt == m_start);
  endfunction

  initial begin : compare
    bit neg;
    wait (chk_en);
    forever begin
      @(clk_in);
      #1;
      neg = !clk_in;
      check("clk_out", 32'(clk_out), 32'(exp_clk(neg)));
      check("tick", 32'(tick), 32'(exp_tick()));
      check("div_busy", 32'(div_busy), 32'(m_pend));
      check("div_err", 32'(div_err), 32'(m_err));
    end
  end

  task automatic half();
    @(clk_in);
    #1;
  endtask

  task automatic pos(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] v);
    div_val  = v;
    div_load = 1'b1;
    pos(1);
    div_load = 1'b0;
  endtask

  task automatic wait_rise();
    for (int i = 0; i < 1200 && clk_out !== 1'b0; i++) half();
    for (int i = 0; i < 1200 && clk_out !== 1'b1; i++) half();
  endtask

  // High time and full period of the next clk_out pulse, in half clk_in cycles.
  task automatic measure(output int hi, output int per);
    wait_rise();
    hi = 0;
    while (clk_out === 1'b1 && hi < 1200) begin
      hi++;
      half();
    end
    per = hi;
    while (clk_out === 1'b0 && per < 1200) begin
      per++;
      half();
    end
  endtask

  task automatic tick_gap(output int gap);
    gap = 0;
    do begin
      pos(1);
      gap++;
    end while (tick !== 1'b1 && gap < 600);
  endtask

  task automatic wait_busy_clear();
    for (int i = 0; i < 600 && div_busy !== 1'b0; i++) pos(1);
    check("busy_clear", 32'(div_busy), 0);
  endtask

  int hi;
  int per;
  int gap;
  int seen;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    #22;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(div_busy), 0);
    check("rst_err", 32'(div_err), 0);
    chk_en = 1;
    rst_n  = 1'b1;

    // Start-up latency with the reset divisor 3.
    pos(1);
    en = 1'b1;
    pos(1);
    check("e0_clk_out", 32'(clk_out), 0);
    check("e0_tick", 32'(tick), 0);
    pos(1);
    check("e1_tick", 32'(tick), 1);
    half();
    check("e1_clk_out_neg", 32'(clk_out), 1);
    measure(hi, per);
    check("n3_high", 32'(hi), 3);
    check("n3_period", 32'(per), 6);
    tick_gap(gap);
    tick_gap(gap);
    check("n3_tick_gap", 32'(gap), 3);

    load(8'd4);
    check("n4_busy_set", 32'(div_busy), 1);
    wait_busy_clear();
    measure(hi, per);
    check("n4_high", 32'(hi), 4);
    check("n4_period", 32'(per), 8);

    load(8'd2);
    wait_busy_clear();
    measure(hi, per);
    check("n2_high", 32'(hi), 2);
    check("n2_period", 32'(per), 4);

    // Running N=5, reload 2 sampled at cnt=1.
    load(8'd5);
    wait_busy_clear();
    tick_gap(gap);
    load(8'd2);
    check("n5_busy_pending", 32'(div_busy), 1);
    tick_gap(gap);
    check("n5_finish_gap", 32'(gap + 1), 5);
    check("n5_busy_done", 32'(div_busy), 0);
    tick_gap(gap);
    check("n2_after_gap", 32'(gap), 2);

    // Illegal loads.
    load(8'd1);
    check("err_on_1", 32'(div_err), 1);
    pos(1);
    check("err_clear_1", 32'(div_err), 0);
    load(8'd0);
    check("err_on_0", 32'(div_err), 1);
    check("err_busy", 32'(div_busy), 0);
    measure(hi, per);
    check("err_keep_period", 32'(per), 4);

    // Stop while clk_out high, N=7.
    load(8'd7);
    wait_busy_clear();
    wait_rise();
    en = 1'b0;
    hi = 0;
    while (clk_out === 1'b1 && hi < 100) begin
      hi++;
      half();
    end
    check("n7_stop_high", 32'(hi), 7);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (clk_out !== 1'b0 || tick !== 1'b0) seen++;
      half();
    end
    check("idle_quiet", 32'(seen), 0);

    // Load applied in IDLE on the next edge; maximum divisor.
    pos(1);
    load(8'd255);
    check("idle_busy_set", 32'(div_busy), 1);
    pos(1);
    check("idle_busy_apply", 32'(div_busy), 0);
    en = 1'b1;
    measure(hi, per);
    check("n255_high", 32'(hi), 255);
    check("n255_period", 32'(per), 510);

    // Asynchronous reset mid-pulse, then restart at DIV_RST.
    for (int i = 0; i < 1200 && clk_out !== 1'b1; i++) half();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 0);
    check("async_rst_tick", 32'(tick), 0);
    @(negedge clk_in);
    #2;
    rst_n = 1'b1;
    measure(hi, per);
    check("post_rst_high", 32'(hi), 3);
    check("post_rst_period", 32'(per), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
